// File: rtl/cla_sub_seq.sv
// Sequential wide subtractor: one SLICE-bit borrow-lookahead slice per clock, LSB first.
// The inter-slice carry (inverted borrow) is held in a register between cycles.
module cla_sub_seq #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int N   = WIDTH / SLICE;
  localparam int NG  = SLICE / 4;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;

  generate
    if (SLICE < 4 || (SLICE % 4) != 0) begin : g_bad_slice
      $error("cla_sub_seq: SLICE must be a positive multiple of 4");
    end
    if (WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_width
      $error("cla_sub_seq: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic             zero_reg;
  logic             ovf_reg;

  logic             last_slice;
  logic [31:0]      ofs;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb_n;
  logic [SLICE-1:0] bit_g;
  logic [SLICE-1:0] bit_p;
  logic [SLICE-1:0] bit_c;
  logic [SLICE-1:0] sum;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] diff_full;

  // Subtraction as a + ~b + ~borrow: the carry chain carries the inverted borrow.
  assign ofs        = 32'(cnt_reg) * 32'(SLICE);
  assign sa         = a_reg[ofs +: SLICE];
  assign sb_n       = ~b_reg[ofs +: SLICE];
  assign bit_g      = sa & sb_n;
  assign bit_p      = sa | sb_n;
  assign last_slice = (cnt_reg == CW'(N - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      logic [3:0] g4;
      logic [3:0] p4;
      logic       c_in;

      assign g4   = bit_g[4*gi +: 4];
      assign p4   = bit_p[4*gi +: 4];
      assign c_in = grp_c[gi];

      assign grp_g[gi] = g4[3]
                       | (p4[3] & g4[2])
                       | (p4[3] & p4[2] & g4[1])
                       | (p4[3] & p4[2] & p4[1] & g4[0]);
      assign grp_p[gi] = &p4;

      assign bit_c[4*gi]     = c_in;
      assign bit_c[4*gi + 1] = g4[0] | (p4[0] & c_in);
      assign bit_c[4*gi + 2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c_in);
      assign bit_c[4*gi + 3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                             | (p4[2] & p4[1] & p4[0] & c_in);
    end
  endgenerate

  // Second level: every group carry is a flat sum-of-products of group G/P and the slice carry-in.
  always_comb begin : p_group_lookahead
    logic acc;
    logic run_p;
    grp_c = '0;
    acc   = 1'b0;
    run_p = 1'b1;
    for (int j = 0; j <= NG; j++) begin
      acc   = 1'b0;
      run_p = 1'b1;
      for (int m = j - 1; m >= 0; m--) begin
        acc   = acc | (run_p & grp_g[m]);
        run_p = run_p & grp_p[m];
      end
      grp_c[j] = acc | (run_p & carry_reg);
    end
  end

  assign sum = sa ^ sb_n ^ bit_c;

  always_comb begin
    diff_full = diff_reg;
    diff_full[ofs +: SLICE] = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_slice) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      diff_reg  <= '0;
      bout_reg  <= 1'b0;
      zero_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= ~bin;
            cnt_reg   <= '0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
            zero_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
          end
        end
        RUN: begin
          diff_reg  <= diff_full;
          carry_reg <= grp_c[NG];
          cnt_reg   <= cnt_reg + 1'b1;
          // Flags use the merged result so they land on the same edge as the last slice.
          if (last_slice) begin
            cnt_reg  <= '0;
            bout_reg <= ~grp_c[NG];
            zero_reg <= ~|diff_full;
            ovf_reg  <= (a_reg[MSB] ^ b_reg[MSB]) & (diff_full[MSB] ^ a_reg[MSB]);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff = diff_reg;
  assign bout = bout_reg;
  assign zero = zero_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_cla_sub_seq.sv
// Directed and randomized checks of cla_sub_seq (WIDTH=64, SLICE=16, four slices per op).
module tb_cla_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        zero;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  cla_sub_seq #(.WIDTH(64), .SLICE(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Called and returns 1 time unit after a rising edge with the DUT idle.
  task automatic do_op(input logic [63:0] ta, input logic [63:0] tb, input logic tbin,
                       output logic [63:0] rd, output logic rb, output logic rz,
                       output logic ro, output int lat);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb; bin = ~tbin;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    rd = diff; rb = bout; rz = zero; ro = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("[TB] op a=%h b=%h bin=%0d -> diff=%h bout=%0d zero=%0d ovf=%0d lat=%0d",
             ta, tb, tbin, rd, rb, rz, ro, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (diff !== 64'd0) begin fails++; $display("FAIL reset_diff got=%h exp=0", diff); end
    tests++; if ({bout, zero, ovf} !== 3'b000) begin fails++; $display("FAIL reset_flags got=%b exp=000", {bout, zero, ovf}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    logic [63:0] d; logic rb, rz, ro; int lat;
    do_op(64'd5, 64'd3, 1'b0, d, rb, rz, ro, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    tests++; if (d !== 64'd2) begin fails++; $display("FAIL basic_diff got=%h exp=%h", d, 64'd2); end
    tests++; if ({rb, rz, ro} !== 3'b000) begin fails++; $display("FAIL basic_flags got=%b exp=000", {rb, rz, ro}); end
  endtask

  task automatic test_borrow();
    logic [63:0] d; logic rb, rz, ro; int lat;
    do_op(64'd0, 64'd1, 1'b0, d, rb, rz, ro, lat);
    tests++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL borrow_wrap_diff got=%h exp=%h", d, 64'hFFFF_FFFF_FFFF_FFFF); end
    tests++; if ({rb, rz, ro} !== 3'b100) begin fails++; $display("FAIL borrow_wrap_flags got=%b exp=100", {rb, rz, ro}); end
    do_op(64'h1_0000, 64'd1, 1'b0, d, rb, rz, ro, lat);
    tests++; if (d !== 64'h0000_0000_0000_FFFF) begin fails++; $display("FAIL borrow_slice_diff got=%h exp=%h", d, 64'h0000_0000_0000_FFFF); end
    tests++; if (rb !== 1'b0) begin fails++; $display("FAIL borrow_slice_bout got=%b exp=0", rb); end
    tests++; if (lat !== 4) begin fails++; $display("FAIL borrow_slice_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_overflow();
    logic [63:0] d; logic rb, rz, ro; int lat;
    do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, d, rb, rz, ro, lat);
    tests++; if (d !== 64'h7FFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL ovf_diff got=%h exp=%h", d, 64'h7FFF_FFFF_FFFF_FFFF); end
    tests++; if ({rb, rz, ro} !== 3'b001) begin fails++; $display("FAIL ovf_flags got=%b exp=001", {rb, rz, ro}); end
  endtask

  task automatic test_zero();
    logic [63:0] d; logic rb, rz, ro; int lat;
    do_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, d, rb, rz, ro, lat);
    tests++; if (d !== 64'd0) begin fails++; $display("FAIL zero_diff got=%h exp=0", d); end
    tests++; if ({rb, rz, ro} !== 3'b010) begin fails++; $display("FAIL zero_flags got=%b exp=010", {rb, rz, ro}); end
    do_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, d, rb, rz, ro, lat);
    tests++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL zero_bin_diff got=%h exp=%h", d, 64'hFFFF_FFFF_FFFF_FFFF); end
    tests++; if ({rb, rz, ro} !== 3'b100) begin fails++; $display("FAIL zero_bin_flags got=%b exp=100", {rb, rz, ro}); end
  endtask

  task automatic test_backpressure();
    int lat;
    a = 64'd100; b = 64'd58; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    tests++; if (lat !== 4) begin fails++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; a = 64'd0; b = 64'd1; bin = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid cycle=%0d got=%b exp=1", c, out_valid); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", c, in_ready); end
      tests++; if (diff !== 64'd42) begin fails++; $display("FAIL bp_diff cycle=%0d got=%h exp=%h", c, diff, 64'd42); end
      tests++; if ({bout, zero, ovf} !== 3'b000) begin fails++; $display("FAIL bp_flags cycle=%0d got=%b exp=000", c, {bout, zero, ovf}); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("[TB] backpressure handoff diff=42 after 3 stalled cycles");
    tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL bp_release got=%b exp=01", {out_valid, in_ready}); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL bp_not_queued got=%b exp=01", {out_valid, in_ready}); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ta, tb, d, exp_d; logic tbin, rb, rz, ro, exp_b, exp_z, exp_o; logic [64:0] r; int lat;
    for (int n = 0; n < 256; n++) begin
      ta = {$urandom, $urandom};
      tb = {$urandom, $urandom};
      if (n % 16 == 3) tb = ta;
      if (n % 16 == 7) tb = ta + 64'd1;
      tbin = 1'($urandom_range(0, 1));
      r = {1'b0, ta} - {1'b0, tb} - {64'd0, tbin};
      exp_d = r[63:0];
      exp_b = r[64];
      exp_z = (exp_d == 64'd0);
      exp_o = (ta[63] ^ tb[63]) & (exp_d[63] ^ ta[63]);
      do_op(ta, tb, tbin, d, rb, rz, ro, lat);
      tests++;
      if (d !== exp_d || {rb, rz, ro} !== {exp_b, exp_z, exp_o} || lat !== 4) begin
        fails++;
        $display("FAIL b2b_vec%0d got diff=%h flags=%b lat=%0d exp diff=%h flags=%b lat=4",
                 n, d, {rb, rz, ro}, lat, exp_d, {exp_b, exp_z, exp_o});
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [63:0] d; logic rb, rz, ro; int lat;
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    $display("[TB] reset pulsed during slice 2");
    tests++; if (diff !== 64'd0) begin fails++; $display("FAIL abort_diff got=%h exp=0", diff); end
    tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL abort_handshake got=%b exp=01", {out_valid, in_ready}); end
    tests++; if ({bout, zero, ovf} !== 3'b000) begin fails++; $display("FAIL abort_flags got=%b exp=000", {bout, zero, ovf}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL abort_release_in_ready got=%b exp=1", in_ready); end
    do_op(64'd10, 64'd4, 1'b0, d, rb, rz, ro, lat);
    tests++; if (d !== 64'd6) begin fails++; $display("FAIL abort_next_diff got=%h exp=%h", d, 64'd6); end
    tests++; if (lat !== 4) begin fails++; $display("FAIL abort_next_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
